// File: rtl/ring_ctrl_pkg.sv
// Shared types and width helpers for the ring token scheduler.
package ring_ctrl_pkg;

    typedef enum logic [1:0] {
        INJ_IDLE = 2'd0,
        INJ_UP   = 2'd1,
        INJ_DN   = 2'd2
    } inj_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ACK  = 1'b1
    } ret_state_e;

    // Width of an index into n items; never below 1 bit.
    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int credit_w(input int max_tok);
        return $clog2(max_tok + 1);
    endfunction

    localparam int OWN_W = owner_w(4);
    localparam int CRD_W = credit_w(3);

endpackage

// File: rtl/async_sync.sv
// Multi-flop synchronizer for one asynchronous input; clears to 0 on reset.
module async_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(d_i);
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ring_token_scheduler.sv
// Round-robin token injector, drainer and cycle-time meter for a 4-phase
// handshake ring shared by N_REQ synchronous clients.
module ring_token_scheduler
    import ring_ctrl_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int MAX_TOK     = 3,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_REQ-1:0]                 req,
    output logic [N_REQ-1:0]                 gnt,
    output logic [N_REQ-1:0]                 done,
    output logic                             lr,
    input  logic                             la,
    input  logic                             rr,
    output logic                             ra,
    output logic [credit_w(MAX_TOK)-1:0]     outstanding,
    output logic [CNT_W-1:0]                 cycle_clks,
    output logic                             cycle_valid,
    output logic                             err,
    output inj_state_e                       dbg_inj_state,
    output ret_state_e                       dbg_ret_state
);

    localparam int OW = owner_w(N_REQ);
    localparam int CW = credit_w(MAX_TOK);
    localparam int PW = owner_w(MAX_TOK);

    logic la_s, rr_s;

    async_sync #(.STAGES(SYNC_STAGES)) u_sync_la (.clk(clk), .rst(rst), .d_i(la), .q_o(la_s));
    async_sync #(.STAGES(SYNC_STAGES)) u_sync_rr (.clk(clk), .rst(rst), .d_i(rr), .q_o(rr_s));

    inj_state_e      inj_state_q;
    ret_state_e      ret_state_q;
    logic [N_REQ-1:0] gnt_q, done_q;
    logic            lr_q, ra_q, err_q;
    logic [OW-1:0]   rr_ptr_q;
    logic [CW-1:0]   outstanding_q;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]   owner_q [MAX_TOK];
    logic [CNT_W-1:0] cnt_q, cycle_clks_q;
    logic            cycle_valid_q, seen_rise_q, la_s_prev_q;

    logic          win_found;
    logic [OW-1:0] win_idx, win_next;
    logic          grant_fire, pop_fire, spurious;
    int            scan_idx;

    // Scan from the slot after the previous winner so every client gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = OW'(scan_idx);
            end
        end
        win_next = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
    end

    assign grant_fire = (inj_state_q == INJ_IDLE) && win_found && (outstanding_q < CW'(MAX_TOK));
    assign pop_fire   = (ret_state_q == R_ACK) && !rr_s && (outstanding_q != '0);
    assign spurious   = (ret_state_q == R_ACK) && !rr_s && (outstanding_q == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            inj_state_q <= INJ_IDLE;
            gnt_q       <= '0;
            lr_q        <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            gnt_q <= '0;
            unique case (inj_state_q)
                INJ_IDLE: if (grant_fire) begin
                    gnt_q       <= N_REQ'(1) << win_idx;
                    lr_q        <= 1'b1;
                    rr_ptr_q    <= win_next;
                    inj_state_q <= INJ_UP;
                end
                INJ_UP: if (la_s) begin
                    lr_q        <= 1'b0;
                    inj_state_q <= INJ_DN;
                end
                INJ_DN: if (!la_s) inj_state_q <= INJ_IDLE;
                default: inj_state_q <= INJ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ret_state_q <= R_IDLE;
            done_q      <= '0;
            ra_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= '0;
            unique case (ret_state_q)
                R_IDLE: if (rr_s) begin
                    ra_q        <= 1'b1;
                    ret_state_q <= R_ACK;
                end
                R_ACK: if (!rr_s) begin
                    ra_q        <= 1'b0;
                    ret_state_q <= R_IDLE;
                    if (pop_fire) done_q <= N_REQ'(1) << owner_q[rd_ptr_q];
                    if (spurious) err_q <= 1'b1;
                end
                default: ret_state_q <= R_IDLE;
            endcase
        end
    end

    // Owner storage needs no reset: the pointers and credit count define validity.
    always_ff @(posedge clk) begin
        if (grant_fire) owner_q[wr_ptr_q] <= win_idx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
        end else begin
            if (grant_fire) wr_ptr_q <= (int'(wr_ptr_q) == MAX_TOK - 1) ? '0 : wr_ptr_q + 1'b1;
            if (pop_fire)   rd_ptr_q <= (int'(rd_ptr_q) == MAX_TOK - 1) ? '0 : rd_ptr_q + 1'b1;
            if (grant_fire && !pop_fire)      outstanding_q <= outstanding_q + 1'b1;
            else if (pop_fire && !grant_fire) outstanding_q <= outstanding_q - 1'b1;
        end
    end

    // The first rise only arms the meter; the second yields a real period.
    always_ff @(posedge clk) begin
        if (!rst) begin
            la_s_prev_q   <= 1'b0;
            cnt_q         <= '0;
            cycle_clks_q  <= '0;
            cycle_valid_q <= 1'b0;
            seen_rise_q   <= 1'b0;
        end else begin
            la_s_prev_q <= la_s;
            if (la_s && !la_s_prev_q) begin
                cycle_clks_q <= cnt_q;
                cnt_q        <= CNT_W'(1);
                seen_rise_q  <= 1'b1;
                if (seen_rise_q) cycle_valid_q <= 1'b1;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign gnt           = gnt_q;
    assign done          = done_q;
    assign lr            = lr_q;
    assign ra            = ra_q;
    assign err           = err_q;
    assign outstanding   = outstanding_q;
    assign cycle_clks    = cycle_clks_q;
    assign cycle_valid   = cycle_valid_q;
    assign dbg_inj_state = inj_state_q;
    assign dbg_ret_state = ret_state_q;

endmodule

// File: doc/ring_token_scheduler.md
# ring_token_scheduler

Clocked controller that shares one self-timed 4-phase handshake ring between `N_REQ` synchronous requesters. It arbitrates round-robin among requesters and injects one token per grant through the ring's left channel (`lr`/`la`). It drains tokens from the right channel (`rr`/`ra`) and returns a completion pulse to each token's owner. It also enforces ring capacity with a credit count and measures ring cycle time in clocks.

## Interface
- `N_REQ`, 4: number of requesters.
- `MAX_TOK`, 3: ring token capacity, i.e. the maximum number of outstanding tokens.
- `CNT_W`, 16: width of the cycle-time counter.
- `SYNC_STAGES`, 2: flop stages on each asynchronous input.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-low.
- `req`  in  N_REQ  level request per client; held until `gnt`.
- `gnt`  out  N_REQ  one-hot, one-cycle pulse; token injection has begun for that client.
- `done`  out  N_REQ  one-hot, one-cycle pulse; that client's token has left the ring.
- `lr`  out  1  ring left request (4-phase).
- `la`  in  1  ring left acknowledge; asynchronous.
- `rr`  in  1  ring right request; asynchronous.
- `ra`  out  1  ring right acknowledge (4-phase).
- `outstanding`  out  clog2(MAX_TOK+1)  tokens currently in the ring.
- `cycle_clks`  out  CNT_W  clocks between the last two rising edges of `la`.
- `cycle_valid`  out  1  `cycle_clks` holds a real measurement.
- `err`  out  1  sticky; a token returned with no owner recorded.

## Operation
- `la` and `rr` pass through `SYNC_STAGES`-flop synchronizers, producing `la_s` and `rr_s`. All control uses only the synchronized versions.

Injection FSM, states IDLE → UP → DN → IDLE:
- IDLE: if any `req` is high and `outstanding` < `MAX_TOK`:
  - pick the winner round-robin, starting at the index after the last winner (index 0 first after reset);
  - register `gnt[w]`=1 and `lr`=1;
  - push `w` into the owner FIFO;
  - go to UP.
- UP: hold `lr`=1 until `la_s`=1, then `lr`=0 and go to DN.
- DN: wait for `la_s`=0, then go to IDLE.
- No new grant is issued while in UP or DN.

Return FSM, states R_IDLE → R_ACK → R_IDLE:
- R_IDLE: on `rr_s`=1, set `ra`=1 and go to R_ACK.
- R_ACK: on `rr_s`=0:
  - set `ra`=0;
  - pop the owner FIFO and pulse `done[owner]`;
  - decrement `outstanding`;
  - go to R_IDLE.
- If the FIFO is empty at the pop, set `err`=1, pulse no `done`, and leave `outstanding` unchanged. The handshake still completes.

Credit and FIFO:
- `outstanding` increments on a grant and decrements on a pop.
- Grant and pop in the same cycle leave `outstanding` unchanged.
- The FIFO has depth `MAX_TOK`. Push never overflows because of the credit check. Pointers wrap modulo `MAX_TOK`.

Cycle measurement:
- The counter increments every clock and saturates at 2^CNT_W−1.
- On each rising edge of `la_s`, the count is copied to `cycle_clks` and the counter restarts at 1.
- `cycle_valid` is set at the second rising edge after reset.

## Timing
- Reset value of every output is 0: `gnt`, `done`, `lr`, `ra`, `outstanding`, `cycle_clks`, `cycle_valid`, `err`. Both FSMs go idle, the FIFO is flushed, the round-robin pointer goes to 0, and the synchronizers clear.
- Reset mid-handshake drops `lr`/`ra` immediately. The ring itself must be reset in the same window by the system.
- Grant latency: `gnt` and `lr` rise one clock after the IDLE cycle in which `req` and credit are both present.
- Release of `lr`: one clock after `la_s` rises, i.e. `SYNC_STAGES`+1 clocks after `la` rises.
- Release of `ra`: `ra` falls, and `done` pulses, one clock after `rr_s` falls.
- Minimum injection period is 2·(`SYNC_STAGES`+1)+1 clocks.
- Dropping `req` before its `gnt` is legal; that client is simply skipped.

## Structure
- Shared package `ring_ctrl_pkg` holds:
  - FSM state enums for injection and return;
  - the owner-ID width, clog2(`N_REQ`);
  - the credit width, clog2(`MAX_TOK`+1).
- Sub-module `async_sync` implements a `SYNC_STAGES`-deep reset-to-0 synchronizer, instantiated for `la` and `rr`.
- The owner FIFO, arbiter, both FSMs and cycle counter stay inline.

## Test plan
- **Single request.** Reset, then `req`=0001 with a behavioural ring model (`la` follows `lr` after 2 ns, `rr` pulses 20 ns later, `ra`→`rr` follows) → `gnt`=0001 once, `lr` completes a full 4-phase handshake, `done`=0001 once, `outstanding` goes 0→1→0.
- **Round robin.** `req`=1111 held → grants in order 0001, 0010, 0100, 1000, 0001; no client is granted twice before the others.
- **Credit limit.** Ring model withholds `rr` and `req`=1111 → exactly 3 grants, then `outstanding`=3 and no further `gnt` until one token returns.
- **Out-of-order owners.** Grants to clients 2, 0, 3 → `done` order 0100, 0001, 1000.
- **Spurious return.** `rr` pulse with no outstanding token → `err`=1 and stays 1, `ra` handshake completes, no `done`, `outstanding`=0.
- **Reset and cycle time.**
  - Ring model with 40-clock loop and `req` held → `cycle_valid`=1 and `cycle_clks`=40 after the second `la` rise.
  - Assert `rst`=0 during UP → all outputs 0 on the next clock.
